// File: rtl/run_supervisor.sv
// Run controller: holds the core in reset, waits for masked done flags, drains, and flags a timeout.
// Outputs are registered and track the state. Optional watch capture is built with RUN_SNAPSHOT_EN.
module run_supervisor #(
  parameter int NUM_DONE       = 1,
  parameter int RESET_CYCLES   = 1,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = 16,
  parameter int DATA_W         = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_DONE-1:0] done_mask,
  input  logic [NUM_DONE-1:0] done_in,
`ifdef RUN_SNAPSHOT_EN
  input  logic [DATA_W-1:0]   watch,
  output logic [DATA_W-1:0]   snapshot,
`endif
  output logic                dut_reset,
  output logic                running,
  output logic                finished,
  output logic                timed_out,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_DONE_OK, S_DONE_TO
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1 || DATA_W < 1 || NUM_DONE < 1) begin : g_bad_cfg
    $error("run_supervisor: TIMEOUT_CYCLES, DATA_W and NUM_DONE must be >= 1");
  end

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_DONE-1:0] mask_q;
  logic [NUM_DONE-1:0] sticky;
  logic                accept;
  logic                complete;
  logic                in_phase;
  logic                dut_reset_d, running_d, finished_d, timed_out_d;

  // Current-cycle done_in counts too, so a single-cycle pulse completes immediately.
  assign complete = (mask_q != '0) && (((sticky | done_in) & mask_q) == mask_q);
  assign in_phase = (state == S_HOLD) || (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE, S_DONE_OK, S_DONE_TO: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (RESET_CYCLES == 0) ? S_RUN : S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        // Completion takes priority over a coincident timeout.
        if (complete)                 next_state = (DRAIN_CYCLES == 0) ? S_DONE_OK : S_DRAIN;
        else if (cnt == TIMEOUT_LAST) next_state = S_DONE_TO;
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) next_state = S_DONE_OK;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort) begin
      next_state = S_IDLE;
      accept     = 1'b0;
    end
  end

  always_comb begin
    dut_reset_d = (next_state == S_IDLE) || (next_state == S_HOLD);
    running_d   = (next_state == S_HOLD) || (next_state == S_RUN) || (next_state == S_DRAIN);
    finished_d  = (next_state == S_DONE_OK) || (next_state == S_DONE_TO);
    timed_out_d = (next_state == S_DONE_TO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dut_reset <= 1'b1;
      running   <= 1'b0;
      finished  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      dut_reset <= dut_reset_d;
      running   <= running_d;
      finished  <= finished_d;
      timed_out <= timed_out_d;
    end
  end

  // Phase counter restarts on every state change, so each phase counts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      cycle_count <= '0;
      mask_q      <= '0;
      sticky      <= '0;
    end else begin
      if (next_state != state) cnt <= '0;
      else if (in_phase)       cnt <= cnt + CNT_W'(1);

      if (accept) begin
        cycle_count <= '0;
        mask_q      <= done_mask;
        sticky      <= '0;
      end else if (state == S_RUN) begin
        sticky <= sticky | done_in;
        if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

`ifdef RUN_SNAPSHOT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              snapshot <= '0;
    else if (accept)                                         snapshot <= '0;
    else if (state == S_RUN && next_state != S_RUN && !abort) snapshot <= watch;
  end
`endif

endmodule

// File: tb/tb_run_supervisor.sv
// Directed bench for run_supervisor (NUM_DONE=3, RESET=1, DRAIN=10, TIMEOUT=100).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_run_supervisor;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  done_mask = '0;
  logic [2:0]  done_in = '0;
  logic        dut_reset, running, finished, timed_out;
  logic [15:0] cycle_count;
`ifdef RUN_SNAPSHOT_EN
  logic [31:0] watch = '0;
  logic [31:0] snapshot;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_supervisor #(
    .NUM_DONE(3), .RESET_CYCLES(1), .DRAIN_CYCLES(10),
    .TIMEOUT_CYCLES(100), .CNT_W(16), .DATA_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .done_mask(done_mask), .done_in(done_in),
`ifdef RUN_SNAPSHOT_EN
    .watch(watch), .snapshot(snapshot),
`endif
    .dut_reset(dut_reset), .running(running), .finished(finished),
    .timed_out(timed_out), .cycle_count(cycle_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the DUT in the first RUN cycle (one HOLD cycle, then RUN).
  task automatic begin_run(input logic [2:0] m);
    done_mask = m;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    check_eq("rst_dut_reset", dut_reset, 1);
    check_eq("rst_running", running, 0);
    check_eq("rst_finished", finished, 0);
    check_eq("rst_timed_out", timed_out, 0);
    check_eq("rst_cycle_count", cycle_count, 0);
`ifdef RUN_SNAPSHOT_EN
    check_eq("rst_snapshot", snapshot, 0);
`endif
    reset = 1'b1;
    step(1);
    check_eq("idle_dut_reset", dut_reset, 1);

    // Single flag pulse in the 21st RUN cycle.
    done_mask = 3'b001;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("t1_hold_dut_reset", dut_reset, 1);
    check_eq("t1_hold_running", running, 1);
    step(1);
    check_eq("t1_run_dut_reset", dut_reset, 0);
    check_eq("t1_run_cc0", cycle_count, 0);
    step(20);
    check_eq("t1_cc20", cycle_count, 20);
    done_in = 3'b001;
`ifdef RUN_SNAPSHOT_EN
    watch = 32'h0000_0040;
`endif
    step(1);
    done_in = 3'b000;
`ifdef RUN_SNAPSHOT_EN
    watch = 32'hdead_beef;
`endif
    check_eq("t1_cc21", cycle_count, 21);
    check_eq("t1_drain_running", running, 1);
    step(9);
    check_eq("t1_drain9_finished", finished, 0);
    step(1);
    check_eq("t1_finished", finished, 1);
    check_eq("t1_timed_out", timed_out, 0);
    check_eq("t1_running", running, 0);
    check_eq("t1_cc_final", cycle_count, 21);
    check_eq("t1_done_dut_reset", dut_reset, 0);
`ifdef RUN_SNAPSHOT_EN
    check_eq("t6_snapshot", snapshot, 32'h0000_0040);
`endif

    // No done flag: timeout after 100 RUN cycles; restart from DONE_OK.
    done_mask = 3'b001;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("t2_cc_cleared", cycle_count, 0);
    check_eq("t2_finished_cleared", finished, 0);
`ifdef RUN_SNAPSHOT_EN
    check_eq("t2_snapshot_cleared", snapshot, 0);
`endif
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("t2_start_ignored", dut_reset, 0);
    check_eq("t2_cc1", cycle_count, 1);
    step(98);
    check_eq("t2_cc99", cycle_count, 99);
    check_eq("t2_not_yet", timed_out, 0);
`ifdef RUN_SNAPSHOT_EN
    watch = 32'h0000_0077;
`endif
    step(1);
    check_eq("t2_timed_out", timed_out, 1);
    check_eq("t2_finished", finished, 1);
    check_eq("t2_cc100", cycle_count, 100);
    check_eq("t2_running", running, 0);
`ifdef RUN_SNAPSHOT_EN
    check_eq("t2_snapshot", snapshot, 32'h0000_0077);
`endif
    step(5);
    check_eq("t2_held_to", timed_out, 1);
    check_eq("t2_held_cc", cycle_count, 100);

    // Mask 101: flag0 at cycle 5, flag2 at cycle 30, flag1 only during DRAIN.
    begin_run(3'b101);
    step(4);
    done_in = 3'b001;
    step(1);
    done_in = 3'b000;
    step(24);
    check_eq("t3_cc29", cycle_count, 29);
    done_in = 3'b100;
    step(1);
    done_in = 3'b000;
    check_eq("t3_cc30", cycle_count, 30);
    step(1);
    check_eq("t3_cc_frozen", cycle_count, 30);
    done_in = 3'b010;
    step(8);
    done_in = 3'b000;
    check_eq("t3_drain9_finished", finished, 0);
    step(1);
    check_eq("t3_finished", finished, 1);
    check_eq("t3_timed_out", timed_out, 0);

    // Completion in RUN cycle 100 coincides with the timeout.
    begin_run(3'b001);
    step(99);
    check_eq("t4_cc99", cycle_count, 99);
    done_in = 3'b001;
    step(1);
    done_in = 3'b000;
    check_eq("t4_cc100", cycle_count, 100);
    check_eq("t4_no_timeout", timed_out, 0);
    check_eq("t4_draining", running, 1);
    step(9);
    check_eq("t4_drain9_finished", finished, 0);
    step(1);
    check_eq("t4_finished", finished, 1);
    check_eq("t4_timed_out", timed_out, 0);

    // Asynchronous reset mid-RUN, then abort mid-DRAIN.
    begin_run(3'b001);
    step(3);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_async_dut_reset", dut_reset, 1);
    check_eq("t5_async_running", running, 0);
    check_eq("t5_async_cc", cycle_count, 0);
    #2 reset = 1'b1;
    step(1);
    check_eq("t5_idle_dut_reset", dut_reset, 1);
    begin_run(3'b001);
    done_in = 3'b001;
    step(1);
    done_in = 3'b000;
    step(3);
    check_eq("t5_in_drain", running, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_eq("t5_abort_dut_reset", dut_reset, 1);
    check_eq("t5_abort_running", running, 0);
    check_eq("t5_abort_finished", finished, 0);

    // Zero mask: flags are ignored, only the timeout ends RUN.
    begin_run(3'b000);
    done_in = 3'b111;
    step(99);
    check_eq("t7_mask0_running", running, 1);
    check_eq("t7_mask0_no_to", timed_out, 0);
    step(1);
    done_in = 3'b000;
    check_eq("t7_mask0_timed_out", timed_out, 1);

    // Abort and start together from DONE_TO: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check_eq("t8_abort_dut_reset", dut_reset, 1);
    check_eq("t8_abort_running", running, 0);
    check_eq("t8_abort_finished", finished, 0);
    check_eq("t8_abort_timed_out", timed_out, 0);
    step(1);
    check_eq("t8_stays_idle", running, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
